// File: rtl/fact_pkg.sv
// Shared definitions for the factorial control unit: state encoding and limits.
package fact_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_MULT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam int DEF_MAX_ITER = 12;
  localparam int N_MAX        = 12;

endpackage

// File: rtl/fact_cu_if.sv
// Host handshake, datapath flags and datapath strobes of the factorial control unit.
interface fact_cu_if;

  logic       GO;
  logic       GT12;
  logic       GT1;
  logic       Ld_CNT;
  logic       EN;
  logic       Sel;
  logic       LdR;
  logic       OE;
  logic       Done;
  logic       Err;
  logic [2:0] CS;

  modport master (
    output GO, GT12, GT1,
    input  Ld_CNT, EN, Sel, LdR, OE, Done, Err, CS
  );

  modport slave (
    input  GO, GT12, GT1,
    output Ld_CNT, EN, Sel, LdR, OE, Done, Err, CS
  );

endinterface

// File: rtl/fact_cu.sv
// Moore control unit sequencing the factorial datapath, with an iteration watchdog
// that aborts a loop running longer than MAX_ITER multiplies.
module fact_cu
  import fact_pkg::*;
#(
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int ITER_W   = 4
) (
  input  logic      CLK,
  input  logic      RST_N,
  fact_cu_if.slave  bus
);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ITER_W-1:0] iter;
  logic [ITER_W-1:0] iter_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      iter  <= iter_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    iter_nxt   = iter;
    bus.Ld_CNT = 1'b0;
    bus.EN     = 1'b0;
    bus.Sel    = 1'b0;
    bus.LdR    = 1'b0;
    bus.OE     = 1'b0;
    bus.Done   = 1'b0;
    bus.Err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.GO) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        bus.Ld_CNT = 1'b1;
        bus.Sel    = 1'b1;
        bus.LdR    = 1'b1;
        iter_nxt   = '0;
        state_nxt  = S_CHECK;
      end
      S_CHECK: begin
        // Range check wins over the loop test so an illegal n never multiplies.
        if (bus.GT12)     state_nxt = S_ERROR;
        else if (bus.GT1) state_nxt = S_MULT;
        else              state_nxt = S_DONE;
      end
      S_MULT: begin
        bus.LdR  = 1'b1;
        bus.EN   = 1'b1;
        iter_nxt = iter + 1'b1;
        if (iter == ITER_LAST) state_nxt = S_ERROR;
        else                   state_nxt = S_CHECK;
      end
      S_DONE: begin
        bus.OE   = 1'b1;
        bus.Done = 1'b1;
        if (!bus.GO) state_nxt = S_IDLE;
      end
      S_ERROR: begin
        bus.Err = 1'b1;
        if (!bus.GO) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.CS = state;

endmodule

// File: tb/tb_fact_cu.sv
// Directed bench for fact_cu: drives it beside a small behavioural datapath and
// a second instance with a short watchdog and GT1 stuck high.
module tb_fact_cu;
  import fact_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   both   = 0;

  fact_cu_if ifc ();
  fact_cu_if wif ();

  fact_cu dut (.CLK(clk), .RST_N(rst_n), .bus(ifc));
  fact_cu #(.MAX_ITER(3), .ITER_W(4)) wdut (.CLK(clk), .RST_N(rst_n), .bus(wif));

  // Behavioural datapath: counter, product register, status flags.
  logic [3:0]  n;
  logic [3:0]  cnt;
  logic [31:0] prod;
  logic [31:0] result;

  assign ifc.GT12 = (n > 4'd12);
  assign ifc.GT1  = (cnt > 4'd1);
  assign wif.GT12 = 1'b0;
  assign wif.GT1  = 1'b1;
  assign result   = ifc.OE ? prod : 32'd0;

  always @(posedge clk) begin
    if (ifc.Ld_CNT)  cnt <= n;
    else if (ifc.EN) cnt <= cnt - 4'd1;
    if (ifc.LdR) prod <= ifc.Sel ? 32'd1 : prod * {28'd0, cnt};
  end

  logic [6:0] outs;
  assign outs = {ifc.Ld_CNT, ifc.EN, ifc.Sel, ifc.LdR, ifc.OE, ifc.Done, ifc.Err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [3:0] nv, output int done_cyc, output int err_cyc,
                     output int mults, output int ldrs);
    done_cyc = -1;
    err_cyc  = -1;
    mults    = 0;
    ldrs     = 0;
    @(negedge clk);
    n      = nv;
    ifc.GO = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.EN)  mults++;
      if (ifc.LdR) ldrs++;
      if (ifc.Done && ifc.Err) both++;
      if (ifc.Done) begin done_cyc = c; break; end
      if (ifc.Err)  begin err_cyc  = c; break; end
    end
  endtask

  int dc, ec, mc, lc;
  int wmults, werr, wdone, found;

  initial begin
    rst_n  = 1'b0;
    ifc.GO = 1'b0;
    wif.GO = 1'b0;
    n      = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {25'd0, outs}, 32'd0);
    chk("reset_cs", {29'd0, ifc.CS}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {29'd0, ifc.CS}, 32'd0);

    // n = 5 with GO held through DONE
    run(4'd5, dc, ec, mc, lc);
    chk("n5_done_cycle", dc, 11);
    chk("n5_no_err", ec, -1);
    chk("n5_mults", mc, 4);
    chk("n5_result", result, 32'd120);
    @(negedge clk);
    chk("n5_done_hold", {29'd0, ifc.CS}, 32'd4);
    ifc.GO = 1'b0;
    @(negedge clk);
    chk("n5_back_idle", {29'd0, ifc.CS}, 32'd0);
    chk("n5_outs_idle", {25'd0, outs}, 32'd0);

    run(4'd0, dc, ec, mc, lc);
    chk("n0_done_cycle", dc, 3);
    chk("n0_mults", mc, 0);
    chk("n0_result", result, 32'd1);
    ifc.GO = 1'b0;
    @(negedge clk);

    run(4'd1, dc, ec, mc, lc);
    chk("n1_done_cycle", dc, 3);
    chk("n1_mults", mc, 0);
    chk("n1_result", result, 32'd1);
    ifc.GO = 1'b0;
    @(negedge clk);

    run(4'd12, dc, ec, mc, lc);
    chk("n12_done_cycle", dc, 25);
    chk("n12_no_err", ec, -1);
    chk("n12_mults", mc, 11);
    chk("n12_result", result, 32'd479001600);
    chk("n12_err_low", {31'd0, ifc.Err}, 32'd0);
    ifc.GO = 1'b0;
    @(negedge clk);

    run(4'd13, dc, ec, mc, lc);
    chk("n13_err_cycle", ec, 3);
    chk("n13_no_done", dc, -1);
    chk("n13_mults", mc, 0);
    chk("n13_ldr_only_load", lc, 1);
    chk("n13_oe_low", {31'd0, ifc.OE}, 32'd0);
    ifc.GO = 1'b0;
    @(negedge clk);
    chk("n13_back_idle", {29'd0, ifc.CS}, 32'd0);
    chk("n13_err_cleared", {31'd0, ifc.Err}, 32'd0);

    run(4'd15, dc, ec, mc, lc);
    chk("n15_err_cycle", ec, 3);
    chk("n15_mults", mc, 0);
    ifc.GO = 1'b0;
    @(negedge clk);

    // Watchdog instance: MAX_ITER=3, GT1 stuck high
    wmults = 0;
    werr   = -1;
    wdone  = 0;
    @(negedge clk);
    wif.GO = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (wif.EN)   wmults++;
      if (wif.Done) wdone++;
      if (wif.Err) begin werr = c; break; end
    end
    chk("wd_err_cycle", werr, 8);
    chk("wd_mults", wmults, 3);
    chk("wd_never_done", wdone, 0);
    wif.GO = 1'b0;
    @(negedge clk);
    chk("wd_back_idle", {29'd0, wif.CS}, 32'd0);

    // Asynchronous reset in the middle of a multiply
    found = 0;
    n      = 4'd5;
    ifc.GO = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifc.CS == 3'd3) begin found = 1; break; end
    end
    chk("mid_reached_mult", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", {25'd0, outs}, 32'd0);
    chk("mid_reset_cs", {29'd0, ifc.CS}, 32'd0);
    ifc.GO = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {29'd0, ifc.CS}, 32'd0);
    chk("post_reset_outs", {25'd0, outs}, 32'd0);

    chk("done_err_exclusive", both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
